// File: rtl/gera_asteroides.sv
// gera_asteroides: asteroid spawner. On a spawn request, scans asteroid memory
// for the lowest free slot and writes a new asteroid there. The direction opcode
// comes from a free-running LFSR, and the entry position lies on the matching
// screen border.
module gera_asteroides #(
   parameter int N_SLOTS = 16,
   parameter int ADDR_W  = 4,
   parameter int COOR_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              gera_aste,
   input  logic              loaded_aste_rd,
   output logic [ADDR_W-1:0] addr_aste,
   output logic              we_aste,
   output logic              loaded_aste_wr,
   output logic [1:0]        opcode_aste_wr,
   output logic [COOR_W-1:0] pos_x_aste_wr,
   output logic [COOR_W-1:0] pos_y_aste_wr,
   output logic              geracao_concluida,
   output logic              sem_espaco,
   output logic [4:0]        db_estado_gera
);

   localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(N_SLOTS - 1);

   typedef enum logic [4:0] {
      S_INICIO      = 5'd0,
      S_ESPERA      = 5'd1,
      S_RESETA_CONT = 5'd2,
      S_VERIFICA    = 5'd3,
      S_INCREMENTA  = 5'd4,
      S_GRAVA       = 5'd5,
      S_SINALIZA    = 5'd6,
      S_CHEIO       = 5'd7
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [7:0]        lfsr_q, lfsr_d;
   logic [COOR_W-1:0] r;

   // Next-state, slot counter and LFSR step
   always_comb begin
      state_d = S_INICIO;
      cnt_d   = cnt_q;
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      case (state_q)
         S_INICIO:      state_d = S_ESPERA;
         S_ESPERA:      state_d = gera_aste ? S_RESETA_CONT : S_ESPERA;
         S_RESETA_CONT: begin
            cnt_d   = '0;
            state_d = S_VERIFICA;
         end
         S_VERIFICA: begin
            if (!loaded_aste_rd)         state_d = S_GRAVA;
            else if (cnt_q == LAST_SLOT) state_d = S_CHEIO;
            else                         state_d = S_INCREMENTA;
         end
         S_INCREMENTA: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_VERIFICA;
         end
         S_GRAVA:       state_d = S_SINALIZA;
         S_SINALIZA:    state_d = S_ESPERA;
         S_CHEIO:       state_d = S_ESPERA;
         default:       state_d = S_INICIO;
      endcase
   end

   // State, counter and LFSR registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_INICIO;
         cnt_q   <= '0;
         lfsr_q  <= 8'hA5;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
      end
   end

   // Moore outputs and write fields decoded from the registered state and LFSR
   always_comb begin
      r                 = lfsr_q[7 -: COOR_W];
      addr_aste         = cnt_q;
      loaded_aste_wr    = 1'b1;
      opcode_aste_wr    = lfsr_q[1:0];
      we_aste           = (state_q == S_GRAVA);
      geracao_concluida = (state_q == S_SINALIZA);
      sem_espaco        = (state_q == S_CHEIO);
      case (lfsr_q[1:0])
         2'b00: begin pos_x_aste_wr = '0; pos_y_aste_wr = r;  end
         2'b01: begin pos_x_aste_wr = '1; pos_y_aste_wr = r;  end
         2'b10: begin pos_x_aste_wr = r;  pos_y_aste_wr = '0; end
         default: begin pos_x_aste_wr = r; pos_y_aste_wr = '1; end
      endcase
      case (state_q)
         S_INICIO, S_ESPERA, S_RESETA_CONT, S_VERIFICA,
         S_INCREMENTA, S_GRAVA, S_SINALIZA, S_CHEIO: db_estado_gera = state_q;
         default:                                    db_estado_gera = 5'b11111;
      endcase
   end

endmodule

// File: tb/tb_gera_asteroides.sv
// Testbench for gera_asteroides: table-driven spawn scenarios plus directed
// sequences for reset, the border rule, dropped requests and mid-scan reset.
module tb_gera_asteroides;

   logic        clock = 1'b0;
   logic        reset;
   logic        gera_aste;
   logic        loaded_aste_rd;
   logic [3:0]  addr_aste;
   logic        we_aste;
   logic        loaded_aste_wr;
   logic [1:0]  opcode_aste_wr;
   logic [3:0]  pos_x_aste_wr;
   logic [3:0]  pos_y_aste_wr;
   logic        geracao_concluida;
   logic        sem_espaco;
   logic [4:0]  db_estado_gera;

   logic [15:0] mem;
   logic [7:0]  m_lfsr;
   int          errors = 0;
   int          checks = 0;

   gera_asteroides #(.N_SLOTS(16), .ADDR_W(4), .COOR_W(4)) dut (
      .clock             (clock),
      .reset             (reset),
      .gera_aste         (gera_aste),
      .loaded_aste_rd    (loaded_aste_rd),
      .addr_aste         (addr_aste),
      .we_aste           (we_aste),
      .loaded_aste_wr    (loaded_aste_wr),
      .opcode_aste_wr    (opcode_aste_wr),
      .pos_x_aste_wr     (pos_x_aste_wr),
      .pos_y_aste_wr     (pos_y_aste_wr),
      .geracao_concluida (geracao_concluida),
      .sem_espaco        (sem_espaco),
      .db_estado_gera    (db_estado_gera)
   );

   always #5 clock = ~clock;

   // Asynchronous-read memory: only the loaded bits matter to the spawner
   assign loaded_aste_rd = mem[addr_aste];

   // Reference LFSR
   always @(posedge clock)
      m_lfsr <= reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // {loaded, opcode, x, y} expected from an LFSR value
   function automatic logic [10:0] exp_fields(input logic [7:0] l);
      logic [3:0] rr;
      rr = l[7:4];
      case (l[1:0])
         2'b00:   return {1'b1, 2'b00, 4'd0,  rr};
         2'b01:   return {1'b1, 2'b01, 4'd15, rr};
         2'b10:   return {1'b1, 2'b10, rr,    4'd0};
         default: return {1'b1, 2'b11, rr,    4'd15};
      endcase
   endfunction

   // Starts at a negedge in espera (cycle 0), runs until espera again or timeout.
   task automatic spawn(input logic [15:0] m, input bit extra,
                        output int we_cyc, output int we_addr, output int n_we,
                        output int conc_cyc, output int full_cyc, output int esp_cyc,
                        output int fld_err, output logic [1:0] opc);
      mem = m;
      we_cyc = -1; we_addr = -1; n_we = 0; conc_cyc = -1; full_cyc = -1;
      esp_cyc = -1; fld_err = 0; opc = 2'b00;
      gera_aste = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clock);
         if (we_aste) begin
            n_we++;
            if (we_cyc < 0) begin
               we_cyc  = c;
               we_addr = int'(addr_aste);
            end
            if ({loaded_aste_wr, opcode_aste_wr, pos_x_aste_wr, pos_y_aste_wr} !== exp_fields(m_lfsr))
               fld_err++;
            opc = opcode_aste_wr;
         end
         if (geracao_concluida && conc_cyc < 0) conc_cyc = c;
         if (sem_espaco && full_cyc < 0)        full_cyc = c;
         if (db_estado_gera == 5'd1) begin
            esp_cyc = c;
            break;
         end
         gera_aste = extra && (c < 10) && c[0];
      end
      gera_aste = 1'b0;
   endtask

   typedef struct {
      logic [15:0] mem;
      int          we_cyc;
      int          addr;
      int          conc_cyc;
      int          full_cyc;
      int          esp_cyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int wc, wa, nw, cc, fc, ec, fe, cnt;
      logic [1:0] op;
      logic [3:0] seen;

      vecs[0] = '{16'h0000,  3,  0,  4, -1,  5};
      vecs[1] = '{16'h001F, 13,  5, 14, -1, 15};
      vecs[2] = '{16'hFFFF, -1,  0, -1, 33, 34};
      vecs[3] = '{16'h7FFF, 33, 15, 34, -1, 35};
      vecs[4] = '{16'h0005,  5,  1,  6, -1,  7};

      reset = 1'b1; gera_aste = 1'b0; mem = '0;
      @(negedge clock);
      @(negedge clock);
      check("rst_state",  int'(db_estado_gera), 0);
      check("rst_we",     int'(we_aste), 0);
      check("rst_conc",   int'(geracao_concluida), 0);
      check("rst_full",   int'(sem_espaco), 0);
      check("rst_addr",   int'(addr_aste), 0);
      check("rst_lfsr",   int'(dut.lfsr_q), 'hA5);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_state", int'(db_estado_gera), 1);
      check("post_rst_lfsr",  int'(dut.lfsr_q), 'h4A);
      check("post_rst_pulses", int'({we_aste, geracao_concluida, sem_espaco}), 0);

      // Table-driven spawn scenarios
      for (int i = 0; i < 5; i++) begin
         spawn(vecs[i].mem, 1'b0, wc, wa, nw, cc, fc, ec, fe, op);
         check($sformatf("v%0d_we_cycle", i),   wc, vecs[i].we_cyc);
         check($sformatf("v%0d_n_writes", i),   nw, (vecs[i].we_cyc >= 0) ? 1 : 0);
         if (vecs[i].we_cyc >= 0)
            check($sformatf("v%0d_addr", i),    wa, vecs[i].addr);
         check($sformatf("v%0d_fields", i),     fe, 0);
         check($sformatf("v%0d_conc_cycle", i), cc, vecs[i].conc_cyc);
         check($sformatf("v%0d_full_cycle", i), fc, vecs[i].full_cyc);
         check($sformatf("v%0d_espera_cycle", i), ec, vecs[i].esp_cyc);
      end

      // Border rule over many spawns into an empty memory
      seen = '0;
      for (int i = 0; i < 200; i++) begin
         spawn(16'h0000, 1'b0, wc, wa, nw, cc, fc, ec, fe, op);
         check($sformatf("border%0d_fields", i), fe, 0);
         check($sformatf("border%0d_writes", i), nw, 1);
         seen[op] = 1'b1;
      end
      check("all_opcodes_seen", int'(seen), 'hF);

      // Extra requests during a scan are dropped
      spawn(16'h001F, 1'b1, wc, wa, nw, cc, fc, ec, fe, op);
      check("extra_n_writes", nw, 1);
      check("extra_addr",     wa, 5);
      check("extra_we_cycle", wc, 13);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (we_aste || db_estado_gera != 5'd1) cnt++;
      end
      check("extra_no_restart", cnt, 0);

      // Reset while in verifica_loaded
      mem = 16'h0000;
      gera_aste = 1'b1;
      @(negedge clock);
      gera_aste = 1'b0;
      @(negedge clock);
      check("midscan_state", int'(db_estado_gera), 3);
      reset = 1'b1;
      @(negedge clock);
      check("midscan_rst_state", int'(db_estado_gera), 0);
      check("midscan_rst_we",    int'(we_aste), 0);
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (we_aste) cnt++;
      end
      check("midscan_no_write", cnt, 0);
      check("midscan_espera",   int'(db_estado_gera), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gera_asteroides.md
# gera_asteroides

Asteroid spawner control unit with its own slot counter and LFSR. On a spawn request it scans the asteroid memory for the first free slot (loaded = 0). It writes a new asteroid there with a pseudo-random direction opcode and an entry position on the matching screen border. It sits directly upstream of the asteroid-movement unit and fills the same memory, whose loaded/opcode/position fields that unit then consumes. The top level guarantees that spawn and move operations never overlap and muxes the memory port.

## Interface
- N_SLOTS, 16: number of asteroid slots in memory.
- ADDR_W, 4: slot address width; N_SLOTS = 2^ADDR_W.
- COOR_W, 4: coordinate width; border value COOR_MAX = 2^COOR_W − 1.
- clock  in  1  system clock; everything updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising clock edge.
- gera_aste  in  1  spawn request; sampled only in state espera.
- loaded_aste_rd  in  1  loaded bit of the slot at addr_aste (asynchronous memory read, valid the same cycle).
- addr_aste  out  ADDR_W  slot address driven to memory (slot counter value).
- we_aste  out  1  memory write enable.
- loaded_aste_wr  out  1  loaded bit written; constant 1.
- opcode_aste_wr  out  2  direction written: 00 horizontal crescente, 01 horizontal decrescente, 10 vertical crescente, 11 vertical decrescente.
- pos_x_aste_wr, pos_y_aste_wr  out  COOR_W each  entry position written.
- geracao_concluida  out  1  one-cycle pulse: asteroid written.
- sem_espaco  out  1  one-cycle pulse: no free slot; nothing written.
- db_estado_gera  out  5  current state code, for debug.

## Operation
- **LFSR**
  - 8 bits, free-running; advances every cycle in every state.
  - Reset value 8'hA5.
  - Update: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It never reaches 0.
- **States and codes**
  - inicio 0: unconditionally → espera.
  - espera 1: → reseta_contador if gera_aste = 1, else stays in espera.
  - reseta_contador 2: counter ← 0; → verifica_loaded.
  - verifica_loaded 3:
    - loaded_aste_rd = 0 → grava.
    - else if counter = N_SLOTS−1 → cheio.
    - else → incrementa_contador.
  - incrementa_contador 4: counter ← counter + 1; → verifica_loaded.
  - grava 5: we_aste = 1; → sinaliza.
  - sinaliza 6: geracao_concluida = 1; → espera.
  - cheio 7: sem_espaco = 1; → espera.
  - Unused codes: db_estado_gera = 5'b11111; next state is inicio.
- **Fields written in grava** (combinational from the LFSR value in that cycle)
  - opcode = lfsr[1:0]; r = lfsr[7:8−COOR_W].
  - Opcode 00: x = 0, y = r.
  - Opcode 01: x = COOR_MAX, y = r.
  - Opcode 10: x = r, y = 0.
  - Opcode 11: x = r, y = COOR_MAX.
- Data outputs are don't-care while we_aste = 0. addr_aste equals the counter at all times.
- The counter never wraps: the scan ends at N_SLOTS−1.
- gera_aste is ignored outside espera. There is no queuing; a request seen while busy is dropped.

## Timing
- **Reset values:** state inicio, counter 0, addr_aste 0, we_aste 0, geracao_concluida 0, sem_espaco 0, db_estado_gera 0, LFSR A5.
- All outputs are Moore outputs decoded from the registered state.
- **Cycle numbering:** cycle 0 = espera with gera_aste = 1.
  - Cycle 1: reseta_contador.
  - Free slot k: verifica_loaded on slot k at cycle 2+2k, grava at 3+2k, sinaliza at 4+2k, espera at 5+2k.
  - All slots loaded: last verifica at 2N_SLOTS, cheio at 2N_SLOTS+1, espera at 2N_SLOTS+2.
- At most one write per request, always to the lowest-index free slot.
- Reset asserted in any state, including mid-scan or in grava: the next state is inicio and the write is aborted.

## Test plan
- **Reset:** reset high for 2 cycles, then low → db_estado_gera 0 then 1; all pulse outputs 0. Internal LFSR is A5, then 4A on the next cycle.
- **Empty memory:** pulse gera_aste → write to slot 0 at cycle 3 with loaded = 1. Opcode and position match the LFSR model, e.g. opcode 01 → x = 15. geracao_concluida at cycle 4.
- **Slots 0–4 loaded:** write to slot 5 at cycle 13; concluida at cycle 14.
- **All 16 loaded:** no we_aste; sem_espaco at cycle 33; back in espera at cycle 34.
- **Border rule:** 200 spawns into memory cleared each time → every write obeys the opcode/border rule, and all 4 opcodes occur.
- **Robustness:**
  - Extra gera_aste pulses during a scan → ignored; exactly one write.
  - Reset asserted in verifica_loaded → no write, next state inicio.
